pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

Program-counter stage directly upstream of the control/decode block. It holds the architectural PC and drives it as `pc_i` to the control block, whose instruction memory is read combinationally. The same cycle, it selects the next PC from the control block's `pc_src_o`, `jalr_pc_src_o` and `imm_op_o` and the ALU result. It also sequences start-up, stall, halt and misaligned-target trap, and keeps a retired-instruction counter.

## Interface
- `ADDR_WIDTH`, 32: PC and target width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `pc_src_i` in 1: branch-taken or JAL; target is PC + imm.
- `jalr_pc_src_i` in 1: JALR; target is ALU result with bit 0 cleared.
- `imm_op_i` in ADDR_WIDTH: sign-extended immediate from the decoder.
- `alu_result_i` in ADDR_WIDTH: rs1 + imm for JALR.
- `stall_i` in 1: hold PC this cycle.
- `halt_i` in 1: the current instruction is the last one; stop after it.
- `pc_o` out ADDR_WIDTH: current PC, registered.
- `pc_plus4_o` out ADDR_WIDTH: `pc_o` + 4, the link value for JAL/JALR.
- `valid_o` out 1: `pc_o` addresses an instruction that executes this cycle.
- `halted_o` out 1: stage is in HALT.
- `misaligned_o` out 1: stage is in TRAP.
- `retired_o` out 32: count of retired instructions.

## Operation
- States:
  - IDLE: after reset; `valid_o` = 0.
  - RUN.
  - HALT.
  - TRAP.
- Transitions:
  - IDLE -> RUN unconditionally on the first clock after reset deasserts. PC is not advanced and inputs are ignored in IDLE.
- Next-target priority:
  1. `jalr_pc_src_i`: (`alu_result_i` & ~1).
  2. `pc_src_i`: `pc_o` + `imm_op_i`.
  3. Otherwise: `pc_o` + 4.
- Arithmetic is modulo 2^ADDR_WIDTH. Carries are discarded and the PC wraps silently.
- RUN, in priority order each cycle:
  - `halt_i` = 1: retired += 1, PC holds, next state HALT. Halt wins over stall and over misalignment.
  - `stall_i` = 1: PC holds, retired holds, stay in RUN. Branch/jump inputs are ignored.
  - Target[1:0] != 0: PC holds, retired holds, next state TRAP. The faulting instruction does not retire.
  - Otherwise: PC <= target, retired += 1.
- HALT and TRAP:
  - Both are terminal; only reset exits them.
  - Outputs in HALT: `valid_o` = 0, `halted_o` = 1.
  - Outputs in TRAP: `valid_o` = 0, `misaligned_o` = 1.
  - All inputs are ignored.
- `retired_o` wraps from 32'hFFFF_FFFF to 0.
- `valid_o` = 1 only in RUN, including stalled cycles.

## Timing
- Reset values:
  - `pc_o` = RESET_VECTOR
  - `pc_plus4_o` = RESET_VECTOR + 4
  - `valid_o` = 0, `halted_o` = 0, `misaligned_o` = 0
  - `retired_o` = 0
  - state = IDLE
- Reset asserted mid-operation clears all state asynchronously, regardless of state.
- The next PC is a combinational function of the inputs, which come from the same-cycle decode of `pc_o`. `pc_o` updates on the following rising edge: one instruction per cycle, no delay slot.
- `pc_plus4_o` is combinational from `pc_o`.
- `halted_o`, `misaligned_o` and `retired_o` are registered. Each changes on the edge that ends the triggering cycle.
- No combinational path from `stall_i` or `halt_i` to any output.

## Structure
- Shared package `fetch_pkg` holds:
  - `fetch_state_t` enum {FS_IDLE, FS_RUN, FS_HALT, FS_TRAP}.
  - Constant `PC_INCR` = 4.
  - Default RESET_VECTOR.
- One combinational sub-module, `pc_next`:
  - Computes the target from the select inputs.
  - Flags misalignment, i.e. target[1:0] != 0.
- The top level holds the state register, the PC register and the retire counter.

## Test plan
- Reset release, no control inputs: cycle 0 IDLE with `pc_o` = 0 and `valid_o` = 0. Then `pc_o` steps 0, 4, 8, C over 4 cycles; `retired_o` = 3 after the third increment.
- At PC 0x10, `pc_src_i` = 1 with `imm_op_i` = 0xFFFF_FFF8: next `pc_o` = 0x08. With `jalr_pc_src_i` = 1 simultaneously and `alu_result_i` = 0x101: `pc_o` = 0x100 (JALR wins, bit 0 cleared).
- `stall_i` high for 3 cycles at PC 0x20 while `pc_src_i` is asserted: `pc_o` stays 0x20 and `retired_o` is unchanged. On release, PC advances normally.
- `pc_src_i` with `imm_op_i` = 2 at PC 0x40: TRAP, `misaligned_o` = 1, `pc_o` stays 0x40, `retired_o` not incremented. The same stimulus together with `halt_i` gives HALT instead.
- `halt_i` at PC 0x30 with `retired_o` = 12: `retired_o` = 13, `halted_o` = 1, `pc_o` = 0x30 thereafter. Asserting `rst_ni` low mid-cycle immediately restores all reset values.
- Preload `retired_o` near wrap (run 2^32-1 instructions, or force the counter): it rolls over to 0 on the next retirement.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_HALT,
    FS_TRAP
  } fetch_state_t;

  localparam int unsigned PC_INCR              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: JALR over branch/JAL over sequential, plus misalignment flag.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_src,
  input  logic                  jalr_pc_src,
  input  logic [ADDR_WIDTH-1:0] imm_op,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] jalr_target;
  logic [ADDR_WIDTH-1:0] branch_target;

  // All sums wrap modulo 2^ADDR_WIDTH; carries are dropped on purpose.
  assign pc_plus4      = pc + ADDR_WIDTH'(PC_INCR);
  assign branch_target = pc + imm_op;
  assign jalr_target   = alu_result & ~ADDR_WIDTH'(1);

  always_comb begin
    target = pc_plus4;
    if (jalr_pc_src) begin
      target = jalr_target;
    end else if (pc_src) begin
      target = branch_target;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_stage.sv
// Architectural PC register, start-up/stall/halt/trap sequencing and retired-instruction counter.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pc_src_i,
  input  logic                  jalr_pc_src_i,
  input  logic [ADDR_WIDTH-1:0] imm_op_i,
  input  logic [ADDR_WIDTH-1:0] alu_result_i,
  input  logic                  stall_i,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o,
  output logic                  halted_o,
  output logic                  misaligned_o,
  output logic [31:0]           retired_o
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           retired_q, retired_d;
  logic [ADDR_WIDTH-1:0] target;
  logic                  target_misaligned;

  pc_next #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_next (
    .pc          (pc_q),
    .pc_src      (pc_src_i),
    .jalr_pc_src (jalr_pc_src_i),
    .imm_op      (imm_op_i),
    .alu_result  (alu_result_i),
    .pc_plus4    (pc_plus4_o),
    .target      (target),
    .misaligned  (target_misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FS_IDLE;
      pc_q      <= RESET_VECTOR;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    unique case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN: begin
        // Halt retires the current instruction even if it is stalled or would trap.
        if (halt_i) begin
          retired_d = retired_q + 32'd1;
          state_d   = FS_HALT;
        end else if (stall_i) begin
          state_d = FS_RUN;
        end else if (target_misaligned) begin
          state_d = FS_TRAP;
        end else begin
          pc_d      = target;
          retired_d = retired_q + 32'd1;
        end
      end
      FS_HALT: state_d = FS_HALT;
      FS_TRAP: state_d = FS_TRAP;
      default: state_d = FS_IDLE;
    endcase
  end

  // Status outputs decode the registered state only, so stall/halt never reach them combinationally.
  assign pc_o         = pc_q;
  assign valid_o      = (state_q == FS_RUN);
  assign halted_o     = (state_q == FS_HALT);
  assign misaligned_o = (state_q == FS_TRAP);
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: vector table plus hand sequences, checked through a queue.
module tb_pc_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pc_src_i = 1'b0;
  logic        jalr_pc_src_i = 1'b0;
  logic [31:0] imm_op_i = 32'd0;
  logic [31:0] alu_result_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        halted_o;
  logic        misaligned_o;
  logic [31:0] retired_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_fetch_stage #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_src_i      (pc_src_i),
    .jalr_pc_src_i (jalr_pc_src_i),
    .imm_op_i      (imm_op_i),
    .alu_result_i  (alu_result_i),
    .stall_i       (stall_i),
    .halt_i        (halt_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o),
    .halted_o      (halted_o),
    .misaligned_o  (misaligned_o),
    .retired_o     (retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [31:0] retired;
  } exp_t;

  typedef struct {
    logic        ps;
    logic        jr;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        st;
    logic        hl;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, " pc"}, pc_o, e.pc);
    chk({tag, " pc_plus4"}, pc_plus4_o, e.pc + 32'd4);
    chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, e.valid});
    chk({tag, " halted"}, {31'd0, halted_o}, {31'd0, e.halted});
    chk({tag, " misaligned"}, {31'd0, misaligned_o}, {31'd0, e.mis});
    chk({tag, " retired"}, retired_o, e.retired);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic v, input logic h,
                              input logic m, input logic [31:0] r);
    exp_t e;
    e.pc = pc; e.valid = v; e.halted = h; e.mis = m; e.retired = r;
    return e;
  endfunction

  // Drive one cycle's inputs, queue the expected post-edge outputs, then check them after the edge.
  task automatic step(input string tag, input logic ps, input logic jr, input logic [31:0] imm,
                      input logic [31:0] alu, input logic st, input logic hl, input exp_t e);
    exp_t got;
    pc_src_i = ps; jalr_pc_src_i = jr; imm_op_i = imm; alu_result_i = alu;
    stall_i = st; halt_i = hl;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 expected 1 entry", tag);
    end else begin
      got = exp_q.pop_front();
      check_outputs(tag, got);
    end
  endtask

  task automatic do_reset(input string tag);
    pc_src_i = 0; jalr_pc_src_i = 0; imm_op_i = 0; alu_result_i = 0; stall_i = 0; halt_i = 0;
    rst_ni = 1'b0;
    #3;
    check_outputs({tag, " in reset"}, mk(32'h0, 0, 0, 0, 32'd0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_outputs({tag, " idle"}, mk(32'h0, 0, 0, 0, 32'd0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h00, 1, 0, 0, 0)};
    vecs[1]  = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h04, 1, 0, 0, 1)};
    vecs[2]  = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h08, 1, 0, 0, 2)};
    vecs[3]  = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h0C, 1, 0, 0, 3)};
    vecs[4]  = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h10, 1, 0, 0, 4)};
    vecs[5]  = '{1, 0, 32'hFFFFFFF8, 32'h0,   0, 0, mk(32'h08, 1, 0, 0, 5)};
    vecs[6]  = '{1, 1, 32'h8,        32'h101, 0, 0, mk(32'h100, 1, 0, 0, 6)};
    vecs[7]  = '{0, 1, 32'h0,        32'h20,  0, 0, mk(32'h20, 1, 0, 0, 7)};
    vecs[8]  = '{1, 0, 32'h40,       32'h0,   1, 0, mk(32'h20, 1, 0, 0, 7)};
    vecs[9]  = '{1, 0, 32'h40,       32'h0,   1, 0, mk(32'h20, 1, 0, 0, 7)};
    vecs[10] = '{1, 0, 32'h40,       32'h0,   1, 0, mk(32'h20, 1, 0, 0, 7)};
    vecs[11] = '{0, 0, 32'h0,        32'h0,   0, 0, mk(32'h24, 1, 0, 0, 8)};
    vecs[12] = '{1, 0, 32'h1C,       32'h0,   0, 0, mk(32'h40, 1, 0, 0, 9)};
    vecs[13] = '{1, 0, 32'h2,        32'h0,   0, 0, mk(32'h40, 0, 0, 1, 9)};
    vecs[14] = '{0, 0, 32'h0,        32'h0,   0, 1, mk(32'h40, 0, 0, 1, 9)};

    do_reset("table");
    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].ps, vecs[i].jr, vecs[i].imm, vecs[i].alu,
           vecs[i].st, vecs[i].hl, vecs[i].e);
    end

    // Halt at 0x30 after twelve retirements, then reset asynchronously mid-cycle.
    do_reset("halt");
    step("halt idle", 0, 0, 0, 0, 0, 0, mk(32'h0, 1, 0, 0, 0));
    for (int i = 1; i <= 12; i++) begin
      step($sformatf("halt run%0d", i), 0, 0, 0, 0, 0, 0, mk(32'(4 * i), 1, 0, 0, 32'(i)));
    end
    step("halt take", 1, 0, 32'h100, 0, 1, 1, mk(32'h30, 0, 1, 0, 13));
    step("halt hold", 1, 1, 32'h4, 32'h200, 0, 0, mk(32'h30, 0, 1, 0, 13));
    step("halt hold2", 0, 0, 0, 0, 0, 1, mk(32'h30, 0, 1, 0, 13));
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs("async reset", mk(32'h0, 0, 0, 0, 0));

    // Halt outranks a misaligned target.
    do_reset("halt-mis");
    step("hm idle", 0, 0, 0, 0, 0, 0, mk(32'h0, 1, 0, 0, 0));
    step("hm jalr", 0, 1, 0, 32'h41, 0, 0, mk(32'h40, 1, 0, 0, 1));
    step("hm halt", 1, 0, 32'h2, 0, 0, 1, mk(32'h40, 0, 1, 0, 2));

    // PC wrap, retired wrap, JALR misalignment from bit 1.
    do_reset("wrap");
    step("wr idle", 0, 0, 0, 0, 0, 0, mk(32'h0, 1, 0, 0, 0));
    step("wr jalr top", 0, 1, 0, 32'hFFFFFFFD, 0, 0, mk(32'hFFFFFFFC, 1, 0, 0, 1));
    step("wr pc wrap", 0, 0, 0, 0, 0, 0, mk(32'h0, 1, 0, 0, 2));
    dut.retired_q = 32'hFFFF_FFFF;
    step("wr ret wrap", 0, 0, 0, 0, 0, 0, mk(32'h4, 1, 0, 0, 0));
    step("wr jalr mis", 0, 1, 0, 32'h6, 0, 0, mk(32'h4, 0, 0, 1, 0));
    step("wr trap hold", 0, 0, 0, 0, 0, 0, mk(32'h4, 0, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
